// File: rtl/addsub_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
// Saturation helpers are used only when ADDSUB_SAT_EN is defined.
package addsub_pkg;

   localparam int SLICE_W   = 4;
   localparam int SAT_MAX_W = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int num_slices(input int width);
      return width / SLICE_W;
   endfunction

   // Largest signed value of the given width, zero-extended to SAT_MAX_W bits.
   function automatic logic [SAT_MAX_W-1:0] sat_max(input int width);
      logic [SAT_MAX_W-1:0] v;
      v = {SAT_MAX_W{1'b0}};
      for (int i = 0; i < SAT_MAX_W; i++) begin
         if (i < width - 1) begin
            v[i] = 1'b1;
         end else begin
            v[i] = 1'b0;
         end
      end
      return v;
   endfunction

   // Smallest signed value of the given width, zero-extended to SAT_MAX_W bits.
   function automatic logic [SAT_MAX_W-1:0] sat_min(input int width);
      logic [SAT_MAX_W-1:0] v;
      v = {SAT_MAX_W{1'b0}};
      for (int i = 0; i < SAT_MAX_W; i++) begin
         if (i == width - 1) begin
            v[i] = 1'b1;
         end else begin
            v[i] = 1'b0;
         end
      end
      return v;
   endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational 4-bit add/subtract slice with explicit carry-in.
// Exposes the carry into the MSB so the caller can derive signed overflow.
module addsub_slice
   import addsub_pkg::*;
(
   input  logic [SLICE_W-1:0] a4,
   input  logic [SLICE_W-1:0] b4,
   input  logic               m,
   input  logic               cin,
   output logic [SLICE_W-1:0] s4,
   output logic               cout,
   output logic               c3
);

   logic [SLICE_W-1:0] bx_s;
   logic [SLICE_W:0]   c_s;

   // Ripple add of A and conditionally inverted B
   always_comb begin
      bx_s   = b4 ^ {SLICE_W{m}};
      c_s    = {(SLICE_W+1){1'b0}};
      s4     = {SLICE_W{1'b0}};
      c_s[0] = cin;
      for (int i = 0; i < SLICE_W; i++) begin
         s4[i]    = a4[i] ^ bx_s[i] ^ c_s[i];
         c_s[i+1] = (a4[i] & bx_s[i]) | (a4[i] & c_s[i]) | (bx_s[i] & c_s[i]);
      end
   end

   assign cout = c_s[SLICE_W];
   assign c3   = c_s[SLICE_W-1];

endmodule

// File: rtl/addsub_seq_ctrl.sv
// WIDTH-bit add/subtract sequenced through one shared 4-bit slice, LSB nibble first.
// Define ADDSUB_SAT_EN to clamp overflowing results and add the sat output.
module addsub_seq_ctrl
   import addsub_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             m,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf,
`ifdef ADDSUB_SAT_EN
   output logic             sat,
`endif
   output logic             busy
);

   localparam int N     = num_slices(WIDTH);
   localparam int IDX_W = $clog2(N);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

`ifdef ADDSUB_SAT_EN
   localparam logic [SAT_MAX_W-1:0] SAT_MAX_FULL = sat_max(WIDTH);
   localparam logic [SAT_MAX_W-1:0] SAT_MIN_FULL = sat_min(WIDTH);
   localparam logic [WIDTH-1:0]     SAT_MAX      = SAT_MAX_FULL[WIDTH-1:0];
   localparam logic [WIDTH-1:0]     SAT_MIN      = SAT_MIN_FULL[WIDTH-1:0];
   logic sat_d, sat_q;
`endif

   state_e             state_d, state_q;
   logic [WIDTH-1:0]   a_d, a_q, b_d, b_q, result_d, result_q;
   logic               m_d, m_q, carry_d, carry_q;
   logic [IDX_W-1:0]   idx_d, idx_q;
   logic               cout_d, cout_q, ovf_d, ovf_q;
   logic               in_ready_d, in_ready_q, out_valid_d, out_valid_q, busy_d, busy_q;

   int                 nib_base_s;
   logic [SLICE_W-1:0] slice_s4;
   logic               slice_cout, slice_c3;

   assign nib_base_s = int'(idx_q) * SLICE_W;

   addsub_slice u_slice (
      .a4   (a_q[nib_base_s +: SLICE_W]),
      .b4   (b_q[nib_base_s +: SLICE_W]),
      .m    (m_q),
      .cin  (carry_q),
      .s4   (slice_s4),
      .cout (slice_cout),
      .c3   (slice_c3)
   );

   // Next-state, datapath update and registered-output decode
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      m_d      = m_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      result_d = result_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
`ifdef ADDSUB_SAT_EN
      sat_d    = sat_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               m_d     = m;
               idx_d   = {IDX_W{1'b0}};
               carry_d = m;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            result_d[nib_base_s +: SLICE_W] = slice_s4;
            carry_d = slice_cout;
            if (idx_q == LAST_IDX) begin
               idx_d   = {IDX_W{1'b0}};
               cout_d  = slice_cout;
               ovf_d   = slice_c3 ^ slice_cout;
               state_d = DONE;
`ifdef ADDSUB_SAT_EN
               // Overflow direction follows A's sign: only same-sign operands can overflow.
               if (slice_c3 ^ slice_cout) begin
                  sat_d = 1'b1;
                  if (a_q[WIDTH-1]) begin
                     result_d = SAT_MIN;
                  end else begin
                     result_d = SAT_MAX;
                  end
               end else begin
                  sat_d = 1'b0;
               end
`endif
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
      busy_d      = (state_d != IDLE);
   end

   // Sequencer state, operands and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= {WIDTH{1'b0}};
         b_q         <= {WIDTH{1'b0}};
         m_q         <= 1'b0;
         idx_q       <= {IDX_W{1'b0}};
         carry_q     <= 1'b0;
         result_q    <= {WIDTH{1'b0}};
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef ADDSUB_SAT_EN
         sat_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         m_q         <= m_d;
         idx_q       <= idx_d;
         carry_q     <= carry_d;
         result_q    <= result_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
`ifdef ADDSUB_SAT_EN
         sat_q       <= sat_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign result    = result_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
`ifdef ADDSUB_SAT_EN
   assign sat       = sat_q;
`endif

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Directed scoreboard bench for addsub_seq_ctrl (WIDTH=16), including the ADDSUB_SAT_EN build.
module tb_addsub_seq_ctrl;

   localparam int W = 16;

   typedef struct packed {
      logic [W-1:0] res;
      logic         c;
      logic         v;
      logic         s;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_ready, m, out_valid, out_ready, cout, ovf, busy;
   logic [W-1:0] a, b, result;
`ifdef ADDSUB_SAT_EN
   logic         sat;
`endif

   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   addsub_seq_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .m         (m),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cout      (cout),
      .ovf       (ovf),
`ifdef ADDSUB_SAT_EN
      .sat       (sat),
`endif
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference: plain wide arithmetic, overflow from operand/result signs.
   function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic im);
      exp_t         e;
      logic [W-1:0] bx;
      logic [W:0]   full;
      bx    = ib ^ {W{im}};
      full  = {1'b0, ia} + {1'b0, bx} + {{W{1'b0}}, im};
      e.res = full[W-1:0];
      e.c   = full[W];
      e.v   = (ia[W-1] == bx[W-1]) && (full[W-1] != ia[W-1]);
      e.s   = 1'b0;
`ifdef ADDSUB_SAT_EN
      if (e.v) begin
         e.s   = 1'b1;
         e.res = ia[W-1] ? 16'h8000 : 16'h7FFF;
      end
`endif
      return e;
   endfunction

   task automatic send(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic im);
      int guard = 0;
      while (in_ready !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      chk("ready_timeout", 32'(guard < 20), 32'd1);
      in_valid = 1'b1;
      a = ia;
      b = ib;
      m = im;
      @(negedge clk);
      in_valid = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      m = 1'($urandom);
   endtask

   task automatic collect(input int hold);
      int   lat = 0;
      exp_t e;
      while (out_valid !== 1'b1 && lat < 20) begin
         chk("in_ready_run", 32'(in_ready), 32'd0);
         chk("busy_run", 32'(busy), 32'd1);
         @(negedge clk);
         lat++;
      end
      chk("latency", 32'(lat), 32'd4);
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
      end else begin
         e = '0;
      end
      for (int k = 0; k <= hold; k++) begin
         chk("result", 32'(result), 32'(e.res));
         chk("cout", 32'(cout), 32'(e.c));
         chk("ovf", 32'(ovf), 32'(e.v));
`ifdef ADDSUB_SAT_EN
         chk("sat", 32'(sat), 32'(e.s));
`endif
         chk("out_valid_done", 32'(out_valid), 32'd1);
         chk("in_ready_done", 32'(in_ready), 32'd0);
         if (k < hold) @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("in_ready_idle", 32'(in_ready), 32'd1);
      chk("out_valid_idle", 32'(out_valid), 32'd0);
   endtask

   task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic im, input int hold);
      sb.push_back(model(ia, ib, im));
      send(ia, ib, im);
      collect(hold);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      m = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(16'h1234, 16'h4321, 1'b0, 0);
      run_op(16'h0005, 16'h0007, 1'b1, 0);
      run_op(16'h0007, 16'h0005, 1'b1, 0);
      run_op(16'hFFFF, 16'h0001, 1'b0, 0);
      run_op(16'h7FFF, 16'h0001, 1'b0, 3);
      run_op(16'h8000, 16'h0001, 1'b1, 0);
      run_op(16'h8000, 16'hFFFF, 1'b0, 1);
      for (int i = 0; i < 4; i++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom), i % 2);
      end

      // Abort an operation at slice index 2 with an asynchronous reset.
      send(16'hABCD, 16'h1111, 1'b0);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_result", 32'(result), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("post_rst_no_valid", 32'(out_valid), 32'd0);
      end
      run_op(16'h00FF, 16'h0001, 1'b0, 0);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
